// File: rtl/kuznechik_pkg.sv
// Shared Kuznechik definitions: GF(2^8) field, linear-transform coefficients, byte mapping.
// Byte a_k of a 128-bit vector lives at bits [127-8k -: 8].
package kuznechik_pkg;

  localparam logic [7:0] GF_POLY = 8'hC3;
  localparam int         NBYTES  = 16;

  // Coefficient of a_k in the l() sum
  localparam logic [7:0] L_COEF [0:15] = '{
    8'd1,   8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,
    8'd251, 8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } fsm_e;

  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] acc;
    x   = a;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ x;
      end
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] v, input int k);
    return v[127-8*k -: 8];
  endfunction

  function automatic logic [127:0] vec128(input logic [7:0] i);
    return {i, 120'd0};
  endfunction

endpackage

// File: rtl/kuznechik_r_step.sv
// One combinational Kuznechik R-step: shift bytes toward a_0, append l(a) as a_15.
// Zero latency, no flow control.
module kuznechik_r_step
  import kuznechik_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  logic [7:0] l_byte;

  always_comb begin
    l_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      l_byte = l_byte ^ gf_mul8(get_byte(state_i, k), L_COEF[k]);
    end
    state_o = {state_i[119:0], l_byte};
  end

endmodule

// File: rtl/kuznechik_const_gen.sv
// Burst generator of round constants C_(code+1) = L(Vec128(code+1)), UNROLL R-steps per clock.
// First constant 16/UNROLL cycles after accept; output held until resp_ready, req_ready only in IDLE.
module kuznechik_const_gen
  import kuznechik_pkg::*;
#(
  parameter int IDX_W  = 5,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [IDX_W:0]   req_cnt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [127:0]     resp_data,
  output logic [IDX_W-1:0] resp_idx,
  output logic             resp_last
);

  localparam int ROUNDS = 16 / UNROLL;
  localparam int STEP_W = $clog2(ROUNDS) + 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ROUNDS - 1);
  localparam logic [IDX_W:0]    REM_ONE   = (IDX_W+1)'(1);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("kuznechik_const_gen: UNROLL must be 1, 2, 4, 8 or 16");
  end
  if (IDX_W < 1 || IDX_W > 7) begin : g_bad_idx_w
    $error("kuznechik_const_gen: IDX_W must be in 1..7");
  end

  fsm_e              fsm_q, fsm_d;
  logic [127:0]      state_q, state_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [IDX_W:0]    rem_q, rem_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [127:0]      data_q, data_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic              last_q, last_d;

  logic [IDX_W-1:0]  nxt_idx;
  logic [127:0]      chain [0:UNROLL];

  // Code k maps to i = k+1; the extra bit keeps code 2^IDX_W-1 from wrapping to 0
  function automatic logic [127:0] code_vec(input logic [IDX_W-1:0] code);
    logic [IDX_W:0] i;
    i = {1'b0, code} + REM_ONE;
    return vec128(8'(i));
  endfunction

  assign chain[0] = state_q;
  for (genvar s = 0; s < UNROLL; s++) begin : g_step
    kuznechik_r_step u_step (
      .state_i (chain[s]),
      .state_o (chain[s+1])
    );
  end

  assign nxt_idx = cur_idx_q + IDX_W'(1);

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    rem_d     = rem_q;
    step_d    = step_q;
    data_d    = data_q;
    ridx_d    = ridx_q;
    last_d    = last_q;

    case (fsm_q)
      ST_IDLE: begin
        if (req_valid) begin
          fsm_d     = ST_CALC;
          state_d   = code_vec(req_idx);
          cur_idx_d = req_idx;
          rem_d     = (req_cnt == '0) ? REM_ONE : req_cnt;
          step_d    = '0;
        end
      end
      ST_CALC: begin
        state_d = chain[UNROLL];
        if (step_q == STEP_LAST) begin
          fsm_d  = ST_OUT;
          step_d = '0;
          data_d = chain[UNROLL];
          ridx_d = cur_idx_q;
          last_d = (rem_q == REM_ONE);
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_OUT: begin
        if (resp_ready) begin
          if (rem_q == REM_ONE) begin
            fsm_d = ST_IDLE;
          end else begin
            fsm_d     = ST_CALC;
            rem_d     = rem_q - REM_ONE;
            cur_idx_d = nxt_idx;
            state_d   = code_vec(nxt_idx);
            step_d    = '0;
          end
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      state_q   <= '0;
      cur_idx_q <= '0;
      rem_q     <= '0;
      step_q    <= '0;
      data_q    <= '0;
      ridx_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      rem_q     <= rem_d;
      step_q    <= step_d;
      data_q    <= data_d;
      ridx_q    <= ridx_d;
      last_q    <= last_d;
    end
  end

  assign req_ready  = (fsm_q == ST_IDLE);
  assign resp_valid = (fsm_q == ST_OUT);
  assign resp_data  = data_q;
  assign resp_idx   = ridx_q;
  assign resp_last  = last_q;

endmodule

// File: tb/tb_kuznechik_const_gen.sv
// Bench for kuznechik_const_gen at UNROLL 1, 16 and 4 against a byte-array model of L(Vec128(i)).
module tb_kuznechik_const_gen;

  localparam int IDX_W = 5;
  localparam int NU    = 3;
  localparam int NC    = 1 << IDX_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a        [NU];
  logic             req_valid_a  [NU];
  logic             req_ready_a  [NU];
  logic [IDX_W-1:0] req_idx_a    [NU];
  logic [IDX_W:0]   req_cnt_a    [NU];
  logic             resp_valid_a [NU];
  logic             resp_ready_a [NU];
  logic [127:0]     resp_data_a  [NU];
  logic [IDX_W-1:0] resp_idx_a   [NU];
  logic             resp_last_a  [NU];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int UR = (g == 0) ? 1 : ((g == 1) ? 16 : 4);
    kuznechik_const_gen #(.IDX_W(IDX_W), .UNROLL(UR)) u_dut (
      .clk        (clk),
      .rst        (rst_a[g]),
      .req_valid  (req_valid_a[g]),
      .req_ready  (req_ready_a[g]),
      .req_idx    (req_idx_a[g]),
      .req_cnt    (req_cnt_a[g]),
      .resp_valid (resp_valid_a[g]),
      .resp_ready (resp_ready_a[g]),
      .resp_data  (resp_data_a[g]),
      .resp_idx   (resp_idx_a[g]),
      .resp_last  (resp_last_a[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_mode [NU];

  logic [127:0] ref_tab [NC];

  function automatic int rounds_of(int u);
    return (u == 0) ? 16 : ((u == 1) ? 1 : 4);
  endfunction

  task automatic check(string nm, int u, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s unit%0d: got %h, expected %h", nm, u, act, exp);
    end
  endtask

  // Carry-less product then reduction by x^8+x^7+x^6+x+1
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [15:0] poly;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int bt = 14; bt >= 8; bt--) begin
      poly = 16'h01C3 << (bt - 8);
      if (p[bt]) p = p ^ poly;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_const(input int i);
    logic [7:0]   a [16];
    logic [7:0]   coef [16];
    logic [7:0]   l;
    logic [127:0] r;
    coef = '{8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
             8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148};
    for (int k = 0; k < 16; k++) a[k] = 8'd0;
    a[0] = 8'(i);
    for (int s = 0; s < 16; s++) begin
      l = 8'd0;
      for (int k = 0; k < 16; k++) l = l ^ ref_gmul(a[k], coef[k]);
      for (int k = 0; k < 15; k++) a[k] = a[k+1];
      a[15] = l;
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = a[k];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level expectation per unit: constants still owed, next code, cycle it becomes visible
  int exp_rem  [NU];
  int exp_code [NU];
  int nxt_at   [NU];

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (rst_a[u]) begin
        exp_rem[u] = 0;
      end else begin
        logic ev;
        ev = (exp_rem[u] != 0) && (cyc >= nxt_at[u]);
        check("resp_valid", u, 128'(resp_valid_a[u]), 128'(ev));
        check("req_ready", u, 128'(req_ready_a[u]), 128'(exp_rem[u] == 0));
        if (ev) begin
          check("resp_data", u, resp_data_a[u], ref_tab[exp_code[u]]);
          check("resp_idx", u, 128'(resp_idx_a[u]), 128'(exp_code[u]));
          check("resp_last", u, 128'(resp_last_a[u]), 128'(exp_rem[u] == 1));
        end
        if (exp_rem[u] == 0 && req_valid_a[u]) begin
          exp_code[u] = int'(req_idx_a[u]);
          exp_rem[u]  = (req_cnt_a[u] == 0) ? 1 : int'(req_cnt_a[u]);
          nxt_at[u]   = cyc + 1 + rounds_of(u);
        end else if (ev && resp_ready_a[u]) begin
          exp_rem[u]  = exp_rem[u] - 1;
          exp_code[u] = (exp_code[u] + 1) % NC;
          nxt_at[u]   = cyc + 1 + rounds_of(u);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < NU; u++) begin
        if (rdy_mode[u] == 0)      resp_ready_a[u] = 1'b1;
        else if (rdy_mode[u] == 1) resp_ready_a[u] = 1'($urandom_range(0, 1));
        else                       resp_ready_a[u] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(int u);
    int n;
    n = 0;
    while (!req_ready_a[u] && n < 3000) begin
      step();
      n++;
    end
    check("idle_within_budget", u, 128'(req_ready_a[u]), 128'(1));
  endtask

  task automatic send(int u, int idx, int cnt);
    wait_ready(u);
    req_valid_a[u] = 1'b1;
    req_idx_a[u]   = IDX_W'(idx);
    req_cnt_a[u]   = (IDX_W+1)'(cnt);
    step();
    req_valid_a[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst_a[u]        = 1'b1;
      req_valid_a[u]  = 1'b0;
      req_idx_a[u]    = '0;
      req_cnt_a[u]    = '0;
      resp_ready_a[u] = 1'b1;
      rdy_mode[u]     = 0;
    end
    for (int i = 0; i < NC; i++) ref_tab[i] = ref_const(i + 1);

    check("pin_code0", 0, ref_tab[0], 128'h019484dd10bd275db87a486c7276a26e);
    check("pin_code1", 0, ref_tab[1], 128'h02ebcb7920b94ebab3f490d8e4ec87dc);
    check("pin_code3", 0, ref_tab[3], 128'h041555f240b19cb7a52be3730b1bcd7b);
    check("pin_code15", 0, ref_tab[15], 128'h1054974ec3813599d1ac0a0f2c6cb22f);
    check("pin_code30", 0, ref_tab[30], 128'h1f14273f33953b64f65f342ea7db0310);
    check("pin_code31", 0, ref_tab[31], 128'h20a8ed9c45c16af1619b141e58d8a75e);

    repeat (3) step();
    for (int u = 0; u < NU; u++) begin
      check("rst_req_ready", u, 128'(req_ready_a[u]), 128'(1));
      check("rst_resp_valid", u, 128'(resp_valid_a[u]), 128'(0));
      check("rst_resp_data", u, resp_data_a[u], 128'd0);
      check("rst_resp_idx", u, 128'(resp_idx_a[u]), 128'd0);
      check("rst_resp_last", u, 128'(resp_last_a[u]), 128'd0);
      rst_a[u] = 1'b0;
    end
    step();

    // single constant
    send(0, 0, 1);
    wait_ready(0);
    check("t1_data", 0, resp_data_a[0], 128'h019484dd10bd275db87a486c7276a26e);
    check("t1_last", 0, 128'(resp_last_a[0]), 128'(1));

    // full 32-constant burst on all unroll factors
    for (int u = 0; u < NU; u++) send(u, 0, 32);
    for (int u = 0; u < NU; u++) begin
      wait_ready(u);
      check("t2_final_data", u, resp_data_a[u], 128'h20a8ed9c45c16af1619b141e58d8a75e);
      check("t2_final_idx", u, 128'(resp_idx_a[u]), 128'd31);
    end

    // backpressure while holding a constant
    rdy_mode[0] = 2;
    send(0, 7, 2);
    for (int n = 0; n < 40 && !resp_valid_a[0]; n++) step();
    repeat (5) step();
    check("t3_hold_valid", 0, 128'(resp_valid_a[0]), 128'(1));
    check("t3_hold_idx", 0, 128'(resp_idx_a[0]), 128'd7);
    check("t3_req_ready", 0, 128'(req_ready_a[0]), 128'(0));
    rdy_mode[0] = 0;
    wait_ready(0);

    // reset mid-calculation
    send(0, 3, 1);
    repeat (5) step();
    rst_a[0] = 1'b1;
    step();
    rst_a[0] = 1'b0;
    check("t4_valid_after_rst", 0, 128'(resp_valid_a[0]), 128'(0));
    check("t4_ready_after_rst", 0, 128'(req_ready_a[0]), 128'(1));
    check("t4_data_after_rst", 0, resp_data_a[0], 128'd0);
    send(0, 3, 1);
    wait_ready(0);
    check("t4_data", 0, resp_data_a[0], 128'h041555f240b19cb7a52be3730b1bcd7b);

    // index wrap
    for (int u = 0; u < NU; u++) send(u, 30, 4);
    for (int u = 0; u < NU; u++) begin
      wait_ready(u);
      check("t5_final_data", u, resp_data_a[u], 128'h02ebcb7920b94ebab3f490d8e4ec87dc);
      check("t5_final_idx", u, 128'(resp_idx_a[u]), 128'd1);
    end

    // request pulses while busy must be ignored
    for (int u = 1; u < NU; u++) begin
      send(u, 5, 3);
      req_valid_a[u] = 1'b1;
      req_idx_a[u]   = IDX_W'(9);
      req_cnt_a[u]   = (IDX_W+1)'(1);
      for (int n = 0; n < 200 && !req_ready_a[u]; n++) step();
      req_valid_a[u] = 1'b0;
      check("t6_last_idx", u, 128'(resp_idx_a[u]), 128'd7);
    end

    // randomized traffic, ready and occasional reset
    for (int u = 0; u < NU; u++) rdy_mode[u] = 1;
    for (int c = 0; c < 4000; c++) begin
      for (int u = 0; u < NU; u++) begin
        rst_a[u]       = ($urandom_range(0, 299) == 0);
        req_valid_a[u] = ($urandom_range(0, 3) == 0);
        req_idx_a[u]   = IDX_W'($urandom_range(0, NC - 1));
        req_cnt_a[u]   = (IDX_W+1)'($urandom_range(0, 6));
      end
      step();
    end
    for (int u = 0; u < NU; u++) begin
      rst_a[u]       = 1'b0;
      req_valid_a[u] = 1'b0;
      rdy_mode[u]    = 0;
    end
    for (int u = 0; u < NU; u++) wait_ready(u);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
